// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward select
// codes, the stall FSM state type, and the per-source priority function.
package hazard_pkg;

   localparam int unsigned FWD_W = 3;

   localparam logic [FWD_W-1:0] FWD_NONE     = 3'd0;
   localparam logic [FWD_W-1:0] FWD_EX_ALU   = 3'd1;
   localparam logic [FWD_W-1:0] FWD_MEM_ALU  = 3'd2;
   localparam logic [FWD_W-1:0] FWD_MEM_LOAD = 3'd3;
   localparam logic [FWD_W-1:0] FWD_WB       = 3'd4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      MC_WAIT    = 2'd2
   } stall_state_t;

   // Youngest matching writer wins: EX, then MEM, then WB.
   function automatic logic [FWD_W-1:0] fwd_select(
      input logic ex_alu_hit,
      input logic mem_alu_hit,
      input logic mem_load_hit,
      input logic wb_hit
   );
      if (ex_alu_hit)        return FWD_EX_ALU;
      else if (mem_alu_hit)  return FWD_MEM_ALU;
      else if (mem_load_hit) return FWD_MEM_LOAD;
      else if (wb_hit)       return FWD_WB;
      else                   return FWD_NONE;
   endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Busy vector for destinations of the out-of-pipe multi-cycle unit.
// A bit is set on issue and cleared on completion; register 0 never tracks.
module mc_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                       ClockInput,
   input  logic                       ResetInputN,
   input  logic                       MC_Issue,
   input  logic [REG_ADDR_W-1:0]      MC_IssueRd,
   input  logic                       MC_Done,
   input  logic [REG_ADDR_W-1:0]      MC_DoneRd,
   output logic [2**REG_ADDR_W-1:0]   MC_BusyVec
);

   logic [2**REG_ADDR_W-1:0] busy_d;

   // Next busy vector: clear first so a same-register issue re-sets the bit.
   always_comb begin
      busy_d = MC_BusyVec;
      if (MC_Done && (MC_DoneRd != '0))
         busy_d[MC_DoneRd] = 1'b0;
      if (MC_Issue && (MC_IssueRd != '0))
         busy_d[MC_IssueRd] = 1'b1;
   end

   // Busy vector register.
   always_ff @(posedge ClockInput or negedge ResetInputN) begin
      if (!ResetInputN)
         MC_BusyVec <= '0;
      else
         MC_BusyVec <= busy_d;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage RAW hazard resolution: per-source forward selects against
// EX/MEM/WB writers, load-use stalls and multi-cycle-unit scoreboard stalls.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W        = 4,
   parameter int unsigned NUM_SRC           = 2,
   parameter int unsigned OPC_W             = 4,
   parameter int unsigned OPC_ALU           = 1,
   parameter int unsigned OPC_LOAD          = 2,
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic                          ClockInput,
   input  logic                          ResetInputN,
   input  logic                          ID_Valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_RSrc,
   input  logic                          EX_Valid,
   input  logic                          MEM_Valid,
   input  logic                          WB_Valid,
   input  logic [REG_ADDR_W-1:0]         EX_Rdestination,
   input  logic [REG_ADDR_W-1:0]         MEM_Rdestination,
   input  logic [REG_ADDR_W-1:0]         WB_Rdestination,
   input  logic [OPC_W-1:0]              EX_OpCode,
   input  logic [OPC_W-1:0]              MEM_OpCode,
   input  logic                          WB_WriteEnable,
   input  logic                          MC_Issue,
   input  logic [REG_ADDR_W-1:0]         MC_IssueRd,
   input  logic                          MC_Done,
   input  logic [REG_ADDR_W-1:0]         MC_DoneRd,
   output logic [NUM_SRC*FWD_W-1:0]      ID_Fwd,
   output logic                          StallRequest,
   output logic [2**REG_ADDR_W-1:0]      MC_BusyVec
);

   localparam logic [2:0] LOAD_CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

   logic ex_alu, ex_load, mem_alu, mem_load, wb_write;
   logic [NUM_SRC*FWD_W-1:0] fwd_d;
   logic [NUM_SRC-1:0]       lu_hit;
   logic [NUM_SRC-1:0]       mc_hit;
   logic                     load_use, mc_hazard;
   stall_state_t             state_q, state_d;
   logic [2:0]               cnt_q, cnt_d;

   assign ex_alu   = EX_Valid  && (EX_OpCode  == OPC_W'(OPC_ALU));
   assign ex_load  = EX_Valid  && (EX_OpCode  == OPC_W'(OPC_LOAD));
   assign mem_alu  = MEM_Valid && (MEM_OpCode == OPC_W'(OPC_ALU));
   assign mem_load = MEM_Valid && (MEM_OpCode == OPC_W'(OPC_LOAD));
   assign wb_write = WB_Valid  && WB_WriteEnable;

   mc_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_scoreboard (
      .ClockInput  (ClockInput),
      .ResetInputN (ResetInputN),
      .MC_Issue    (MC_Issue),
      .MC_IssueRd  (MC_IssueRd),
      .MC_Done     (MC_Done),
      .MC_DoneRd   (MC_DoneRd),
      .MC_BusyVec  (MC_BusyVec)
   );

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR_W-1:0] src;
      logic                  live;
      assign src  = ID_RSrc[i*REG_ADDR_W +: REG_ADDR_W];
      assign live = ID_Valid && (src != '0);
      assign fwd_d[i*FWD_W +: FWD_W] = live ?
         fwd_select(ex_alu   && (src == EX_Rdestination),
                    mem_alu  && (src == MEM_Rdestination),
                    mem_load && (src == MEM_Rdestination),
                    wb_write && (src == WB_Rdestination)) : FWD_NONE;
      assign lu_hit[i] = live && ex_load && (src == EX_Rdestination);
      assign mc_hit[i] = live && MC_BusyVec[src];
   end

   assign load_use  = |lu_hit;
   assign mc_hazard = |mc_hit;

   // Stall FSM next state; load-use is served before any MCU wait.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (load_use) begin
               state_d = LOAD_STALL;
               cnt_d   = LOAD_CNT_INIT;
            end else if (mc_hazard) begin
               state_d = MC_WAIT;
            end
         end
         LOAD_STALL: begin
            if (cnt_q == '0)
               state_d = mc_hazard ? MC_WAIT : IDLE;
            else
               cnt_d = cnt_q - 3'd1;
         end
         MC_WAIT: begin
            if (!mc_hazard)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge ClockInput or negedge ResetInputN) begin
      if (!ResetInputN) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         StallRequest <= 1'b0;
         ID_Fwd       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         StallRequest <= (state_d != IDLE);
         ID_Fwd       <= fwd_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed checks of forward selection, load-use stalls, MCU scoreboard
// stalls and asynchronous reset for hazard_forward_unit.
module tb_hazard_forward_unit;

   localparam int unsigned RW = 4;
   localparam int unsigned NS = 2;

   logic          ClockInput = 1'b0;
   logic          ResetInputN = 1'b1;
   logic          ID_Valid;
   logic [NS*RW-1:0] ID_RSrc;
   logic          EX_Valid, MEM_Valid, WB_Valid;
   logic [RW-1:0] EX_Rdestination, MEM_Rdestination, WB_Rdestination;
   logic [3:0]    EX_OpCode, MEM_OpCode;
   logic          WB_WriteEnable;
   logic          MC_Issue, MC_Done;
   logic [RW-1:0] MC_IssueRd, MC_DoneRd;
   logic [NS*3-1:0] ID_Fwd;
   logic          StallRequest;
   logic [15:0]   MC_BusyVec;

   int checks = 0;
   int failures = 0;

   hazard_forward_unit #(
      .REG_ADDR_W        (4),
      .NUM_SRC           (2),
      .OPC_W             (4),
      .OPC_ALU           (1),
      .OPC_LOAD          (2),
      .LOAD_STALL_CYCLES (3)
   ) dut (
      .ClockInput       (ClockInput),
      .ResetInputN      (ResetInputN),
      .ID_Valid         (ID_Valid),
      .ID_RSrc          (ID_RSrc),
      .EX_Valid         (EX_Valid),
      .MEM_Valid        (MEM_Valid),
      .WB_Valid         (WB_Valid),
      .EX_Rdestination  (EX_Rdestination),
      .MEM_Rdestination (MEM_Rdestination),
      .WB_Rdestination  (WB_Rdestination),
      .EX_OpCode        (EX_OpCode),
      .MEM_OpCode       (MEM_OpCode),
      .WB_WriteEnable   (WB_WriteEnable),
      .MC_Issue         (MC_Issue),
      .MC_IssueRd       (MC_IssueRd),
      .MC_Done          (MC_Done),
      .MC_DoneRd        (MC_DoneRd),
      .ID_Fwd           (ID_Fwd),
      .StallRequest     (StallRequest),
      .MC_BusyVec       (MC_BusyVec)
   );

   always #5 ClockInput = ~ClockInput;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ClockInput);
      #1;
   endtask

   task automatic idle_inputs();
      ID_Valid = 1'b0; ID_RSrc = '0;
      EX_Valid = 1'b0; MEM_Valid = 1'b0; WB_Valid = 1'b0;
      EX_Rdestination = '0; MEM_Rdestination = '0; WB_Rdestination = '0;
      EX_OpCode = '0; MEM_OpCode = '0; WB_WriteEnable = 1'b0;
      MC_Issue = 1'b0; MC_IssueRd = '0; MC_Done = 1'b0; MC_DoneRd = '0;
   endtask

   task automatic set_src(input logic [RW-1:0] s0, input logic [RW-1:0] s1);
      ID_Valid = 1'b1;
      ID_RSrc  = {s1, s0};
   endtask

   initial begin
      idle_inputs();
      #2 ResetInputN = 1'b0;
      tick(); tick();
      check("rst_fwd",   32'(ID_Fwd),       32'h0);
      check("rst_stall", 32'(StallRequest), 32'h0);
      check("rst_busy",  32'(MC_BusyVec),   32'h0);
      #3 ResetInputN = 1'b1;

      // EX ALU forwarding to both sources
      EX_Valid = 1; EX_Rdestination = 3; EX_OpCode = 1; set_src(3, 3);
      tick();
      check("ex_both_fwd",   32'(ID_Fwd),       32'h09);
      check("ex_both_stall", 32'(StallRequest), 32'h0);
      EX_Valid = 0;
      tick();
      check("ex_invalid", 32'(ID_Fwd), 32'h00);

      // Priority EX > MEM load > WB
      idle_inputs();
      MEM_Valid = 1; MEM_Rdestination = 5; MEM_OpCode = 2;
      EX_Valid = 1; EX_Rdestination = 5; EX_OpCode = 1; set_src(5, 0);
      tick();
      check("ex_over_mem", 32'(ID_Fwd), 32'h01);
      EX_Valid = 0;
      tick();
      check("mem_load",       32'(ID_Fwd),       32'h03);
      check("mem_load_stall", 32'(StallRequest), 32'h0);
      MEM_Valid = 0; WB_Valid = 1; WB_WriteEnable = 1; WB_Rdestination = 5;
      tick();
      check("wb_fwd", 32'(ID_Fwd), 32'h04);
      WB_WriteEnable = 0;
      tick();
      check("wb_no_we", 32'(ID_Fwd), 32'h00);
      WB_WriteEnable = 1; ID_Valid = 0;
      tick();
      check("id_invalid", 32'(ID_Fwd), 32'h00);
      // MEM ALU on slot 1 beats WB to the same register
      set_src(0, 5); MEM_Valid = 1; MEM_Rdestination = 5; MEM_OpCode = 1;
      tick();
      check("mem_alu_slot1", 32'(ID_Fwd), 32'h10);

      // Load-use stall: exactly three cycles
      idle_inputs();
      EX_Valid = 1; EX_OpCode = 2; EX_Rdestination = 2; set_src(0, 2);
      tick();
      check("lu_stall_0", 32'(StallRequest), 32'h1);
      EX_Valid = 0;
      tick();
      check("lu_stall_1", 32'(StallRequest), 32'h1);
      tick();
      check("lu_stall_2", 32'(StallRequest), 32'h1);
      tick();
      check("lu_release", 32'(StallRequest), 32'h0);

      // Load to r0 never stalls
      EX_Valid = 1; EX_OpCode = 2; EX_Rdestination = 0; set_src(0, 0);
      tick();
      check("lu_r0", 32'(StallRequest), 32'h0);
      // Load-use with ID empty never stalls
      EX_Rdestination = 2; set_src(0, 2); ID_Valid = 0;
      tick();
      check("lu_id_invalid", 32'(StallRequest), 32'h0);

      // MCU scoreboard stall on r7
      idle_inputs();
      MC_Issue = 1; MC_IssueRd = 7;
      tick();
      MC_Issue = 0;
      check("mc_busy_set",  32'(MC_BusyVec),   32'h0080);
      check("mc_pre_stall", 32'(StallRequest), 32'h0);
      set_src(7, 0);
      tick();
      check("mc_stall_0", 32'(StallRequest), 32'h1);
      tick(); tick();
      check("mc_stall_hold", 32'(StallRequest), 32'h1);
      MC_Done = 1; MC_DoneRd = 7;
      tick();
      MC_Done = 0;
      check("mc_busy_clr",   32'(MC_BusyVec),   32'h0000);
      check("mc_stall_last", 32'(StallRequest), 32'h1);
      tick();
      check("mc_release", 32'(StallRequest), 32'h0);

      // Same-cycle issue/done: set wins; r0 ignored
      idle_inputs();
      MC_Issue = 1; MC_IssueRd = 4; MC_Done = 1; MC_DoneRd = 4;
      tick();
      check("mc_set_wins", 32'(MC_BusyVec), 32'h0010);
      tick();
      check("mc_set_wins_again", 32'(MC_BusyVec), 32'h0010);
      MC_Issue = 0;
      tick();
      check("mc_done_r4", 32'(MC_BusyVec), 32'h0000);
      MC_Done = 0; MC_Issue = 1; MC_IssueRd = 0;
      tick();
      MC_Issue = 0;
      check("mc_issue_r0", 32'(MC_BusyVec), 32'h0000);

      // Load-use and MCU hazard together: load stall then MCU wait
      MC_Issue = 1; MC_IssueRd = 6;
      tick();
      MC_Issue = 0;
      EX_Valid = 1; EX_OpCode = 2; EX_Rdestination = 6; set_src(6, 0);
      tick();
      EX_Valid = 0;
      for (int k = 0; k < 4; k++) begin
         check("lu_then_mc", 32'(StallRequest), 32'h1);
         tick();
      end
      check("lu_then_mc_4", 32'(StallRequest), 32'h1);
      MC_Done = 1; MC_DoneRd = 6;
      tick();
      MC_Done = 0;
      check("lu_then_mc_done", 32'(StallRequest), 32'h1);
      tick();
      check("lu_then_mc_rel", 32'(StallRequest), 32'h0);

      // Asynchronous reset mid load stall with busy bits set
      idle_inputs();
      MC_Issue = 1; MC_IssueRd = 9;
      tick();
      MC_Issue = 0;
      WB_Valid = 1; WB_WriteEnable = 1; WB_Rdestination = 1;
      EX_Valid = 1; EX_OpCode = 2; EX_Rdestination = 2; set_src(1, 2);
      tick();
      EX_Valid = 0;
      check("pre_rst_stall", 32'(StallRequest), 32'h1);
      check("pre_rst_fwd",   32'(ID_Fwd),       32'h04);
      check("pre_rst_busy",  32'(MC_BusyVec),   32'h0200);
      #2 ResetInputN = 1'b0;
      #1;
      check("async_rst_stall", 32'(StallRequest), 32'h0);
      check("async_rst_fwd",   32'(ID_Fwd),       32'h00);
      check("async_rst_busy",  32'(MC_BusyVec),   32'h0000);
      idle_inputs();
      tick();
      #3 ResetInputN = 1'b1;
      tick();
      check("post_rst_stall_0", 32'(StallRequest), 32'h0);
      tick();
      check("post_rst_stall_1", 32'(StallRequest), 32'h0);
      check("post_rst_busy",    32'(MC_BusyVec),   32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
